// File: rtl/dcache_pkg.sv
// Shared definitions for the write-back data cache: miss FSM states and
// address-field width helpers.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    DONE
  } state_t;

  // Word-offset field width.
  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Set-index field width.
  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Tag width: everything above index, offset and the two byte bits.
  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned line_words,
                                        input int unsigned sets);
    return addr_w - off_w(line_words) - idx_w(sets) - 2;
  endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// Replaces one 32-bit word of a cache line when enabled; otherwise the line
// passes through unchanged.
module dcache_line_merge
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic [32*LINE_WORDS-1:0]      line,
  input  logic [31:0]                   word,
  input  logic [off_w(LINE_WORDS)-1:0]  offset,
  input  logic                          enable,
  output logic [32*LINE_WORDS-1:0]      merged
);

  localparam int unsigned OFF = off_w(LINE_WORDS);

  // Overwrite the selected word slot.
  always_comb begin
    merged = line;
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      if (enable && offset == OFF'(i)) merged[i*32 +: 32] = word;
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back data cache with line fill / writeback interface.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned SETS       = 64,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    En,
  input  logic                    RW,
  input  logic [31:0]             WData,
  input  logic [ADDR_W-1:0]       Address,
  output logic [31:0]             RData,
  output logic                    Stall,
  output logic                    MemReq,
  output logic                    MemWe,
  output logic [ADDR_W-1:0]       MemAddr,
  output logic [32*LINE_WORDS-1:0] MemWLine,
  input  logic                    MemAck,
  input  logic [32*LINE_WORDS-1:0] MemRLine
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             HitCount,
  output logic [31:0]             MissCount
`endif
);

  localparam int unsigned OFF    = off_w(LINE_WORDS);
  localparam int unsigned IDX    = idx_w(SETS);
  localparam int unsigned TAG    = tag_w(ADDR_W, LINE_WORDS, SETS);
  localparam int unsigned LINE_W = 32 * LINE_WORDS;

  // Address fields of the live CPU request.
  logic [OFF-1:0] a_off;
  logic [IDX-1:0] a_idx;
  logic [TAG-1:0] a_tag;
  logic           unused_byte_bits;

  assign a_off            = Address[OFF+1:2];
  assign a_idx            = Address[IDX+OFF+1:OFF+2];
  assign a_tag            = Address[ADDR_W-1:IDX+OFF+2];
  assign unused_byte_bits = &{1'b0, Address[1:0]};

  // Cache arrays.
  logic [LINE_W-1:0] data_mem [SETS];
  logic [TAG-1:0]    tag_mem  [SETS];
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;

  // Miss context captured on the first cycle of a miss.
  logic [TAG-1:0] m_tag;
  logic [IDX-1:0] m_idx;
  logic [OFF-1:0] m_off;
  logic           m_rw;
  logic [31:0]    m_wdata;

  state_t state, nstate;

  logic [LINE_W-1:0] cur_line;
  logic [31:0]       rd_word;
  logic              lookup_ok, hit, miss_start, vic_dirty;
  logic              fill_write, store_write, wr_en;
  logic [LINE_W-1:0] mg_line, merged;
  logic [31:0]       mg_word;
  logic [OFF-1:0]    mg_off;
  logic              mg_en;
  logic [IDX-1:0]    wr_idx;

  assign cur_line    = data_mem[a_idx];
  assign lookup_ok   = (state == IDLE) || (state == DONE);
  assign hit         = En && lookup_ok && valid[a_idx] && (tag_mem[a_idx] == a_tag);
  assign miss_start  = (state == IDLE) && En && !hit;
  assign vic_dirty   = valid[a_idx] && dirty[a_idx];
  assign fill_write  = (state == FILL) && MemAck;
  assign store_write = hit && RW;
  assign wr_en       = fill_write || store_write;

  // Fill merge and store hit share one merge unit; they never coincide.
  assign mg_line = fill_write ? MemRLine : cur_line;
  assign mg_word = fill_write ? m_wdata  : WData;
  assign mg_off  = fill_write ? m_off    : a_off;
  assign mg_en   = fill_write ? m_rw     : 1'b1;
  assign wr_idx  = fill_write ? m_idx    : a_idx;

  dcache_line_merge #(
    .LINE_WORDS(LINE_WORDS)
  ) u_merge (
    .line   (mg_line),
    .word   (mg_word),
    .offset (mg_off),
    .enable (mg_en),
    .merged (merged)
  );

  // Select the addressed word of the looked-up line.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      if (a_off == OFF'(i)) rd_word = cur_line[i*32 +: 32];
    end
  end

  assign RData = hit ? rd_word : '0;

  // Line data and tag storage; needs no reset since valid gates every use.
  always_ff @(posedge Clk) begin
    if (wr_en) data_mem[wr_idx] <= merged;
    if (fill_write) tag_mem[m_idx] <= m_tag;
  end

  // State, valid/dirty bits, miss context and statistics.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      valid   <= '0;
      dirty   <= '0;
      m_tag   <= '0;
      m_idx   <= '0;
      m_off   <= '0;
      m_rw    <= 1'b0;
      m_wdata <= '0;
`ifdef DCACHE_STATS_EN
      HitCount  <= '0;
      MissCount <= '0;
`endif
    end else begin
      state <= nstate;
      if (miss_start) begin
        m_tag   <= a_tag;
        m_idx   <= a_idx;
        m_off   <= a_off;
        m_rw    <= RW;
        m_wdata <= WData;
      end
      if (fill_write) begin
        valid[m_idx] <= 1'b1;
        dirty[m_idx] <= m_rw;
      end else if (store_write) begin
        dirty[a_idx] <= 1'b1;
      end
`ifdef DCACHE_STATS_EN
      if (state == IDLE && En) begin
        if (hit) HitCount  <= HitCount + 32'd1;
        else     MissCount <= MissCount + 32'd1;
      end
`endif
    end
  end

  // Next state and memory-side outputs.
  always_comb begin
    nstate   = state;
    Stall    = 1'b0;
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = '0;
    MemWLine = '0;
    case (state)
      IDLE: begin
        if (miss_start) begin
          Stall  = 1'b1;
          nstate = vic_dirty ? WB : FILL;
        end
      end
      WB: begin
        Stall    = 1'b1;
        MemReq   = 1'b1;
        MemWe    = 1'b1;
        MemAddr  = {tag_mem[m_idx], m_idx, {(OFF+2){1'b0}}};
        MemWLine = data_mem[m_idx];
        if (MemAck) nstate = FILL;
      end
      FILL: begin
        Stall   = 1'b1;
        MemReq  = 1'b1;
        MemAddr = {m_tag, m_idx, {(OFF+2){1'b0}}};
        if (MemAck) nstate = DONE;
      end
      DONE: begin
        Stall  = En && !hit;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb (default parameters). Build with
// DCACHE_STATS_EN defined to also check the hit/miss counters.
module tb_dcache_wb;

  logic         Clk = 1'b0;
  logic         Rst, En, RW;
  logic [31:0]  WData, Address, RData, MemAddr;
  logic         Stall, MemReq, MemWe, MemAck;
  logic [255:0] MemWLine, MemRLine;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HitCount, MissCount;
`endif

  dcache_wb #(.LINE_WORDS(8), .SETS(64), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .RW(RW), .WData(WData), .Address(Address),
    .RData(RData), .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWLine(MemWLine), .MemAck(MemAck), .MemRLine(MemRLine)
`ifdef DCACHE_STATS_EN
    , .HitCount(HitCount), .MissCount(MissCount)
`endif
  );

  always #5 Clk = ~Clk;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  // Memory contents written back; untouched lines read as a fixed pattern.
  logic [255:0] mem [logic [31:0]];

  // Cache model: what each set holds.
  bit           mv [64];
  bit           md [64];
  logic [20:0]  mt [64];
  logic [255:0] mdat [64];
  int unsigned  mhits = 0, mmisses = 0;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wline;
    int unsigned  lat;
  } xfer_t;
  xfer_t xq[$];

  typedef struct {
    logic         hit;
    logic [31:0]  rdata;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    logic [31:0]  fill_addr;
    int unsigned  stalls;
  } res_t;

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         hit;
    logic [31:0]  rdata;
    logic         wb;
    logic [31:0]  wb_addr;
    int unsigned  wb_sel;
    logic [31:0]  wb_word;
    logic [31:0]  fill_addr;
    int unsigned  stalls;
  } vec_t;

  int unsigned lat_lo = 1, lat_hi = 1, cur_lat = 1;
  bit          spur_en = 0;

  function automatic logic [31:0] pat(input logic [31:0] la, input int unsigned w);
    return 32'hA5A5_0000 + (la >> 8) + (32'(w) << 12);
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem.exists(la)) return mem[la];
    for (int unsigned w = 0; w < 8; w++) l[w*32 +: 32] = pat(la, w);
    return l;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
  endtask

  task automatic abort(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting for the DUT", name);
    summary();
    $finish;
  endtask

  // Memory responder: acks each request after cur_lat extra cycles.
  initial begin
    int unsigned cnt = 0;
    MemAck   = 1'b0;
    MemRLine = '0;
    forever begin
      @(negedge Clk);
      MemAck = 1'b0;
      for (int unsigned w = 0; w < 8; w++) MemRLine[w*32 +: 32] = $urandom;
      if (Rst) begin
        cnt = 0;
      end else if (MemReq) begin
        if (cnt == cur_lat) begin
          MemAck = 1'b1;
          if (!MemWe) MemRLine = mem_line(MemAddr);
          xq.push_back('{MemWe, MemAddr, MemWLine, cur_lat});
          cnt = 0;
          cur_lat = $urandom_range(lat_hi, lat_lo);
        end else begin
          cnt++;
        end
      end else if (spur_en && $urandom_range(3, 0) == 0) begin
        MemAck = 1'b1;
      end
    end
  end

  // One CPU access, starting just after a rising edge; returns observations.
  task automatic access(input logic rw, input logic [31:0] addr,
                        input logic [31:0] wd, output res_t r);
    logic [5:0]   ix;
    logic [20:0]  tg;
    int unsigned  off, stall_n, exp_stall;
    logic         mh, exp_wb;
    logic [31:0]  la, va;
    logic [255:0] line;
    ix = addr[10:5];
    tg = addr[31:11];
    off = 32'(addr[4:2]);
    la = {addr[31:5], 5'b0};
    r = '{hit: 0, rdata: 0, wb: 0, wb_addr: 0, wb_line: 0, fill_addr: 0, stalls: 0};
    mh = mv[ix] && (mt[ix] == tg);
    En = 1'b1; RW = rw; Address = addr; WData = wd;
    @(negedge Clk);
    if (mh) mhits++; else mmisses++;
    r.hit = !Stall;
    check("stall_first", Stall, !mh);
    check("memreq_first", MemReq, 0);
    if (mh) begin
      r.rdata = RData;
      if (!rw) check("rdata_hit", RData, mdat[ix][off*32 +: 32]);
      @(posedge Clk); #1;
      if (rw) begin
        mdat[ix][off*32 +: 32] = wd;
        md[ix] = 1'b1;
      end
      En = 1'b0;
      return;
    end
    check("rdata_miss", RData, 0);
    stall_n = 1;
    forever begin
      @(negedge Clk);
      if (!Stall) break;
      stall_n++;
      if (stall_n > 100) abort("miss_done");
    end
    r.rdata = RData;
    r.stalls = stall_n;
    exp_wb = mv[ix] && md[ix];
    va = {mt[ix], ix, 5'b0};
    check("xfer_count", xq.size(), exp_wb ? 2 : 1);
    exp_stall = 1;
    foreach (xq[k]) begin
      exp_stall += xq[k].lat + 1;
      if (xq[k].we) begin
        r.wb = 1'b1;
        r.wb_addr = xq[k].addr;
        r.wb_line = xq[k].wline;
      end else begin
        r.fill_addr = xq[k].addr;
      end
    end
    if (exp_wb) begin
      check("wb_first", (xq.size() > 0) && xq[0].we, 1);
      check("wb_addr", r.wb_addr, va);
      check("wb_line", r.wb_line, mdat[ix]);
      mem[va] = mdat[ix];
    end
    check("fill_addr", r.fill_addr, la);
    check("stall_cycles", stall_n, exp_stall);
    line = mem_line(la);
    if (rw) line[off*32 +: 32] = wd;
    mdat[ix] = line; mt[ix] = tg; mv[ix] = 1'b1; md[ix] = rw;
    if (!rw) check("rdata_done", RData, line[off*32 +: 32]);
    xq.delete();
    @(posedge Clk); #1;
    En = 1'b0;
  endtask

  initial begin
    vec_t vt[8];
    res_t r;
    int unsigned n;
    logic [31:0] a;
    logic [255:0] line;

    vt[0] = '{0, 32'h100,  0,            0, 32'hA5A5_0001, 0, 0,      0, 0,            32'h100,  3};
    vt[1] = '{0, 32'h100,  0,            1, 32'hA5A5_0001, 0, 0,      0, 0,            0,        0};
    vt[2] = '{1, 32'h104,  32'hDEADBEEF, 1, 0,             0, 0,      0, 0,            0,        0};
    vt[3] = '{0, 32'h4104, 0,            0, 32'hA5A5_1041, 1, 32'h100, 1, 32'hDEADBEEF, 32'h4100, 5};
    vt[4] = '{1, 32'h208,  32'h12345678, 0, 0,             0, 0,      0, 0,            32'h200,  3};
    vt[5] = '{0, 32'h208,  0,            1, 32'h12345678,  0, 0,      0, 0,            0,        0};
    vt[6] = '{0, 32'h200,  0,            1, 32'hA5A5_0002, 0, 0,      0, 0,            0,        0};
    vt[7] = '{0, 32'h4208, 0,            0, 32'hA5A5_2042, 1, 32'h200, 2, 32'h12345678, 32'h4200, 5};

    Rst = 1'b1; En = 1'b0; RW = 1'b0; WData = '0; Address = '0;
    #12;
    check("reset_memreq", MemReq, 0);
    check("reset_memwe", MemWe, 0);
    check("reset_memaddr", MemAddr, 0);
    check("reset_stall", Stall, 0);
    check("reset_rdata", RData, 0);
`ifdef DCACHE_STATS_EN
    check("reset_hits", HitCount, 0);
    check("reset_misses", MissCount, 0);
`endif
    @(negedge Clk); Rst = 1'b0;
    @(posedge Clk); #1;

    // Directed sequence with one-cycle memory latency.
    for (int i = 0; i < 8; i++) begin
      access(vt[i].rw, vt[i].addr, vt[i].wdata, r);
      check($sformatf("v%0d_hit", i), r.hit, vt[i].hit);
      if (!vt[i].rw) check($sformatf("v%0d_rdata", i), r.rdata, vt[i].rdata);
      check($sformatf("v%0d_stalls", i), r.stalls, vt[i].stalls);
      if (!vt[i].hit) begin
        check($sformatf("v%0d_wb", i), r.wb, vt[i].wb);
        check($sformatf("v%0d_fill_addr", i), r.fill_addr, vt[i].fill_addr);
        if (vt[i].wb) begin
          check($sformatf("v%0d_wb_addr", i), r.wb_addr, vt[i].wb_addr);
          check($sformatf("v%0d_wb_word", i), r.wb_line[vt[i].wb_sel*32 +: 32], vt[i].wb_word);
        end
      end
`ifdef DCACHE_STATS_EN
      if (i == 3) begin
        check("stats_hits", HitCount, mhits);
        check("stats_misses", MissCount, mmisses);
      end
`endif
    end

    // Reset while a fill is outstanding.
    lat_lo = 5; lat_hi = 5; cur_lat = 5;
    Address = 32'h300; RW = 1'b0; En = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n > 20) abort("fill_request");
    end while (!(MemReq && !MemWe));
    #2 Rst = 1'b1;
    #1;
    check("rst_fill_memreq", MemReq, 0);
    check("rst_fill_memaddr", MemAddr, 0);
    En = 1'b0;
    #1;
    check("rst_fill_stall", Stall, 0);
    check("rst_fill_rdata", RData, 0);
    check("rst_fill_memwe", MemWe, 0);
    @(posedge Clk); @(posedge Clk); #2 Rst = 1'b0;
    foreach (mv[s]) begin mv[s] = 0; md[s] = 0; end
    mhits = 0; mmisses = 0;
    xq.delete();
    lat_lo = 1; lat_hi = 1; cur_lat = 1;
    @(posedge Clk); #1;
    access(0, 32'h300, 0, r);
    check("reload_after_rst_miss", r.hit, 0);

    // En dropped mid-miss: the registered store data must still be merged.
    lat_lo = 0; lat_hi = 2;
    Address = 32'h500; RW = 1'b1; WData = 32'hCAFEF00D; En = 1'b1;
    @(negedge Clk);
    mmisses++;
    check("endrop_stall", Stall, 1);
    @(posedge Clk); #1;
    En = 1'b0; RW = 1'b0; WData = '0; Address = 32'h9990_0000;
    n = 0;
    while (xq.size() == 0) begin
      @(negedge Clk);
      n++;
      if (n > 40) abort("endrop_fill");
    end
    check("endrop_fill_addr", xq[0].addr, 32'h500);
    check("endrop_fill_we", xq[0].we, 0);
    xq.delete();
    repeat (3) @(posedge Clk);
    #1;
    line = mem_line(32'h500);
    line[31:0] = 32'hCAFEF00D;
    mdat[40] = line; mt[40] = '0; mv[40] = 1'b1; md[40] = 1'b1;
    access(0, 32'h500, 0, r);
    check("endrop_hit", r.hit, 1);
    check("endrop_rdata", r.rdata, 32'hCAFEF00D);

    // Randomized traffic over a small address pool to force conflicts.
    spur_en = 1;
    for (int k = 0; k < 400; k++) begin
      a = 32'(($urandom_range(3, 0) << 11) | ($urandom_range(3, 0) << 5) |
              ($urandom_range(7, 0) << 2) | $urandom_range(3, 0));
      access(1'($urandom_range(1, 0)), a, $urandom, r);
      if ($urandom_range(3, 0) == 0) begin
        @(posedge Clk); #1;
      end
    end
`ifdef DCACHE_STATS_EN
    check("final_hits", HitCount, mhits);
    check("final_misses", MissCount, mmisses);
`endif

    summary();
    $finish;
  end

endmodule
